// File: rtl/ps2_keycode_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------
// | Module  : ps2_keycode_rx_if
// | Brief   : PS/2 line inputs and decoded keycode / event outputs.
// | Revision: 1.0
// +---------------------------------------------------------------------------
interface ps2_keycode_rx_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keycode;
   logic        key_press;
   logic        key_release;
   logic        frame_err;

   // master: keyboard-side driver that also observes the decoded results
   modport master (
      output ps2_clk, ps2_data,
      input  keycode, key_press, key_release, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output keycode, key_press, key_release, frame_err
   );
endinterface
`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------
// | Module  : ps2_keycode_rx
// | Brief   : PS/2 set-2 receiver; maps WASD / arrow keys to held HID keycode.
// | Revision: 1.0
// +---------------------------------------------------------------------------
module ps2_keycode_rx #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   ps2_keycode_rx_if.slave  bus
);

   localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_prev;
   logic                   w_clk_s;
   logic                   w_data;
   logic                   w_fall;

   state_t                 r_state;
   state_t                 w_state_nx;
   logic [2:0]             r_bitcnt;
   logic [7:0]             r_shift;
   logic                   r_parity;
   logic [c_TO_W-1:0]      r_to_cnt;
   logic                   w_byte_rdy;
   logic                   w_bit_err;
   logic                   w_timeout;

   logic                   r_ext;
   logic                   r_brk;
   logic [7:0]             r_key;
   logic                   r_key_press;
   logic                   r_key_release;
   logic                   r_frame_err;
   logic [7:0]             w_hid;
   logic                   w_mapped;

   // Lines idle high, so the synchronisers reset to 1 to avoid a fake edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2_data};
         r_clk_prev  <= w_clk_s;
      end
   end

   assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
   assign w_data  = r_data_sync[SYNC_STAGES-1];
   assign w_fall  = r_clk_prev & ~w_clk_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_bitcnt <= 3'd0;
         r_shift  <= 8'h00;
         r_parity <= 1'b0;
         r_to_cnt <= '0;
      end else begin
         r_state <= w_state_nx;
         if (r_state == IDLE || w_fall) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         if (w_fall) begin
            case (r_state)
               IDLE:    r_bitcnt <= 3'd0;
               DATA: begin
                  r_bitcnt <= r_bitcnt + 3'd1;
                  r_shift  <= {w_data, r_shift[7:1]};
               end
               PARITY:  r_parity <= w_data;
               default: ;
            endcase
         end
      end
   end

   // Timeout is checked first so an abort never coincides with a byte.
   always_comb begin
      w_state_nx = r_state;
      w_byte_rdy = 1'b0;
      w_bit_err  = 1'b0;
      w_timeout  = 1'b0;
      if (r_state != IDLE && !w_fall && r_to_cnt == c_TO_LAST) begin
         w_timeout  = 1'b1;
         w_state_nx = IDLE;
      end else if (w_fall) begin
         case (r_state)
            IDLE:   if (!w_data) w_state_nx = DATA;
            DATA:   if (r_bitcnt == 3'd7) w_state_nx = PARITY;
            PARITY: w_state_nx = STOP;
            STOP: begin
               w_state_nx = IDLE;
               if ((^{r_shift, r_parity}) && w_data) begin
                  w_byte_rdy = 1'b1;
               end else begin
                  w_bit_err = 1'b1;
               end
            end
            default: w_state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      w_hid    = 8'h00;
      w_mapped = 1'b1;
      case ({r_ext, r_shift})
         9'h01D:  w_hid = 8'h1A;
         9'h01C:  w_hid = 8'h04;
         9'h01B:  w_hid = 8'h16;
         9'h023:  w_hid = 8'h07;
         9'h175:  w_hid = 8'h1A;
         9'h16B:  w_hid = 8'h04;
         9'h172:  w_hid = 8'h16;
         9'h174:  w_hid = 8'h07;
         default: w_mapped = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ext         <= 1'b0;
         r_brk         <= 1'b0;
         r_key         <= 8'h00;
         r_key_press   <= 1'b0;
         r_key_release <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_key_press   <= 1'b0;
         r_key_release <= 1'b0;
         r_frame_err   <= 1'b0;
         if (w_timeout || w_bit_err) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_frame_err <= 1'b1;
         end else if (w_byte_rdy) begin
            if (r_shift == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               if (w_mapped && !r_brk) begin
                  r_key       <= w_hid;
                  r_key_press <= 1'b1;
               end else if (w_mapped && w_hid == r_key) begin
                  r_key         <= 8'h00;
                  r_key_release <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.keycode     = {8'h00, r_key};
   assign bus.key_press   = r_key_press;
   assign bus.key_release = r_key_release;
   assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------
// | Module  : tb_ps2_keycode_rx
// | Brief   : Directed bench for ps2_keycode_rx with hand-computed keycodes.
// | Revision: 1.0
// +---------------------------------------------------------------------------
module tb_ps2_keycode_rx;
   localparam int c_TO   = 200;
   localparam int c_HALF = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   n_press = 0, n_rel = 0, n_err = 0, n_overlap = 0;

   ps2_keycode_rx_if bus ();

   ps2_keycode_rx #(.TIMEOUT_CYCLES(c_TO), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         n_press += int'(bus.key_press);
         n_rel   += int'(bus.key_release);
         n_err   += int'(bus.frame_err);
         if (int'(bus.key_press) + int'(bus.key_release) + int'(bus.frame_err) > 1)
            n_overlap++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bus.ps2_data = bits[i];
         tick(c_HALF);
         bus.ps2_clk = 1'b0;
         tick(c_HALF);
         bus.ps2_clk = 1'b1;
      end
      tick(c_HALF);
      bus.ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic flip, input logic stop);
      logic [10:0] f;
      f = {stop, ~(^b) ^ flip, b, 1'b0};
      send_bits(f, 11);
      tick(10);
   endtask

   task automatic test_reset;
      tick(5);
      vectors++;
      if (bus.keycode !== 16'h0000 || bus.key_press !== 1'b0 ||
          bus.key_release !== 1'b0 || bus.frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs got kc=%h p=%b r=%b e=%b exp all 0",
                  bus.keycode, bus.key_press, bus.key_release, bus.frame_err);
      end
      rst_n = 1'b1;
      tick(5);
   endtask

   task automatic test_make_w;
      int p0 = n_press;
      send_byte(8'h1D, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h001A) begin
         miscompares++; $display("FAIL t1_keycode got=%h exp=001a", bus.keycode);
      end
      vectors++;
      if (n_press - p0 !== 1) begin
         miscompares++; $display("FAIL t1_press_cycles got=%0d exp=1", n_press - p0);
      end
   endtask

   task automatic test_extended;
      int p0, r0;
      send_byte(8'hF0, 1'b0, 1'b1);
      r0 = n_rel;
      send_byte(8'h1D, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0000 || n_rel - r0 !== 1) begin
         miscompares++;
         $display("FAIL w_release got kc=%h rel=%0d exp kc=0000 rel=1", bus.keycode, n_rel - r0);
      end
      p0 = n_press; r0 = n_rel;
      send_byte(8'hE0, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0000 || n_press != p0 || n_rel != r0) begin
         miscompares++;
         $display("FAIL t2_e0_quiet got kc=%h p=%0d r=%0d exp kc=0000 p=0 r=0",
                  bus.keycode, n_press - p0, n_rel - r0);
      end
      send_byte(8'h75, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h001A || n_press - p0 !== 1) begin
         miscompares++;
         $display("FAIL t2_up_make got kc=%h p=%0d exp kc=001a p=1", bus.keycode, n_press - p0);
      end
      p0 = n_press; r0 = n_rel;
      send_byte(8'hE0, 1'b0, 1'b1);
      send_byte(8'hF0, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h001A || n_press != p0 || n_rel != r0) begin
         miscompares++;
         $display("FAIL t2_prefix_quiet got kc=%h p=%0d r=%0d exp kc=001a p=0 r=0",
                  bus.keycode, n_press - p0, n_rel - r0);
      end
      send_byte(8'h75, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0000 || n_rel - r0 !== 1 || n_press != p0) begin
         miscompares++;
         $display("FAIL t2_up_break got kc=%h r=%0d exp kc=0000 r=1", bus.keycode, n_rel - r0);
      end
   endtask

   task automatic test_override;
      int r0;
      send_byte(8'h1D, 1'b0, 1'b1);
      send_byte(8'h1C, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0004) begin
         miscompares++; $display("FAIL t3_last_wins got=%h exp=0004", bus.keycode);
      end
      r0 = n_rel;
      send_byte(8'hF0, 1'b0, 1'b1);
      send_byte(8'h1D, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0004 || n_rel != r0) begin
         miscompares++;
         $display("FAIL t3_other_break got kc=%h r=%0d exp kc=0004 r=0", bus.keycode, n_rel - r0);
      end
      send_byte(8'hF0, 1'b0, 1'b1);
      send_byte(8'h1C, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0000 || n_rel - r0 !== 1) begin
         miscompares++;
         $display("FAIL t3_own_break got kc=%h r=%0d exp kc=0000 r=1", bus.keycode, n_rel - r0);
      end
   endtask

   task automatic test_errors;
      int e0, p0;
      e0 = n_err;
      send_byte(8'h1C, 1'b1, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0000 || n_err - e0 !== 1) begin
         miscompares++;
         $display("FAIL t4_parity got kc=%h err=%0d exp kc=0000 err=1", bus.keycode, n_err - e0);
      end
      send_byte(8'h1C, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0004) begin
         miscompares++; $display("FAIL t4_recover got=%h exp=0004", bus.keycode);
      end
      p0 = n_press;
      send_byte(8'h75, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0004 || n_press != p0) begin
         miscompares++;
         $display("FAIL keypad_unmapped got kc=%h p=%0d exp kc=0004 p=0", bus.keycode, n_press - p0);
      end
      e0 = n_err;
      send_byte(8'hE0, 1'b1, 1'b1);
      send_byte(8'h74, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0004 || n_press != p0 || n_err - e0 !== 1) begin
         miscompares++;
         $display("FAIL bad_prefix got kc=%h p=%0d err=%0d exp kc=0004 p=0 err=1",
                  bus.keycode, n_press - p0, n_err - e0);
      end
      e0 = n_err;
      send_byte(8'h23, 1'b0, 1'b0);
      vectors++;
      if (bus.keycode !== 16'h0004 || n_err - e0 !== 1 || n_press != p0) begin
         miscompares++;
         $display("FAIL stop_bit got kc=%h err=%0d exp kc=0004 err=1", bus.keycode, n_err - e0);
      end
      e0 = n_err;
      send_bits(11'h7FF, 3);
      tick(10);
      vectors++;
      if (n_err != e0 || bus.keycode !== 16'h0004) begin
         miscompares++;
         $display("FAIL idle_ones got err=%0d kc=%h exp err=0 kc=0004", n_err - e0, bus.keycode);
      end
      send_byte(8'hF0, 1'b0, 1'b1);
      send_byte(8'h1C, 1'b0, 1'b1);
   endtask

   task automatic test_timeout;
      int e0;
      logic [10:0] f;
      e0 = n_err;
      f = {1'b1, 1'b1, 8'h23, 1'b0};
      send_bits(f, 6);
      tick(c_TO + 50);
      vectors++;
      if (n_err - e0 !== 1 || bus.keycode !== 16'h0000) begin
         miscompares++;
         $display("FAIL t5_timeout got err=%0d kc=%h exp err=1 kc=0000", n_err - e0, bus.keycode);
      end
      send_byte(8'h23, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0007 || n_err - e0 !== 1) begin
         miscompares++;
         $display("FAIL t5_recover got kc=%h err=%0d exp kc=0007 err=1", bus.keycode, n_err - e0);
      end
   endtask

   task automatic test_reset_midframe;
      int p0, r0;
      logic [10:0] f;
      send_byte(8'hF0, 1'b0, 1'b1);
      f = {1'b1, ~(^8'h1B), 8'h1B, 1'b0};
      send_bits(f, 4);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.keycode !== 16'h0000 || bus.key_press !== 1'b0 ||
          bus.key_release !== 1'b0 || bus.frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL t6_async_reset got kc=%h p=%b r=%b e=%b exp all 0",
                  bus.keycode, bus.key_press, bus.key_release, bus.frame_err);
      end
      tick(5);
      rst_n = 1'b1;
      tick(5);
      p0 = n_press; r0 = n_rel;
      send_byte(8'h1B, 1'b0, 1'b1);
      vectors++;
      if (bus.keycode !== 16'h0016 || n_press - p0 !== 1 || n_rel != r0) begin
         miscompares++;
         $display("FAIL t6_make_after got kc=%h p=%0d r=%0d exp kc=0016 p=1 r=0",
                  bus.keycode, n_press - p0, n_rel - r0);
      end
   endtask

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      test_reset();
      test_make_w();
      test_extended();
      test_override();
      test_errors();
      test_timeout();
      test_reset_midframe();
      vectors++;
      if (n_overlap !== 0) begin
         miscompares++; $display("FAIL pulse_overlap got=%0d exp=0", n_overlap);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
